cpu_subsys_mem_arb: RTL and testbench

CPU_SUBSYS_MEM_ARB -- requirements
Module: cpu_subsys_mem_arb

---
 rtl/cpu_subsys_mem_arb.sv | 184 ++++++++++++++++++
 tb/tb_cpu_subsys_mem_arb.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_subsys_mem_arb.sv
// cpu_subsys_mem_arb
//
// Two-master, single-slave memory arbiter for the CPU subsystem. Each master
// issues a request by holding mN_valid high with its address, write data and
// byte strobes (wstrb == 0 means read). The arbiter grants one master at a
// time, forwards that master's request straight through to the slave, and
// returns the slave's completion (s_ready / s_rdata) to the granted master.
//
// Arbitration is round-robin: on a tie the master that was not granted last
// wins, and master 0 wins the first tie after reset. A transaction takes one
// arbitration cycle (IDLE) plus at least one slave cycle (ACTIVE).
//
// A slave that stalls for TIMEOUT_CYCLES waiting cycles is abandoned. The
// master then gets a ready pulse with ERR_RDATA as read data, and err pulses
// for that cycle. If the granted master drops its request mid-transaction,
// the request is withdrawn from the slave and no ready is returned.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   m0_valid / m1_valid       master request
//   m0_ready / m1_ready       master completion (one-cycle pulse)
//   m0_addr  / m1_addr        master address
//   m0_wdata / m1_wdata       master write data
//   m0_wstrb / m1_wstrb       master byte strobes, 0 = read
//   m0_rdata / m1_rdata       master read data (0 when not granted)
//   s_valid, s_addr, s_wdata, s_wstrb   slave request side
//   s_ready, s_rdata          slave completion side
//   err                       one-cycle pulse on timeout completion

module cpu_subsys_mem_arb #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,

    output logic        err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_t      state;
    logic        grant;       // master currently (or most recently) granted
    logic        last_grant;  // master that last completed a transaction
    logic [15:0] wait_cnt;    // ACTIVE cycles spent with s_ready low

    // Granted master's request, selected by the registered grant.
    logic        gnt_valid;
    logic [31:0] gnt_addr;
    logic [31:0] gnt_wdata;
    logic [3:0]  gnt_wstrb;

    // Per-cycle outcome of an ACTIVE cycle.
    logic        active;
    logic        done_ok;     // slave completed
    logic        done_to;     // wait limit reached with slave still stalled
    logic        aborted;     // granted master withdrew its request
    logic        done_any;

    // Arbitration decision taken in IDLE.
    logic        req_any;
    logic        next_grant;

    always_comb begin
        gnt_valid = grant ? m1_valid : m0_valid;
        gnt_addr  = grant ? m1_addr  : m0_addr;
        gnt_wdata = grant ? m1_wdata : m0_wdata;
        gnt_wstrb = grant ? m1_wstrb : m0_wstrb;
    end

    always_comb begin
        active   = (state == ACTIVE);
        aborted  = active && !gnt_valid;
        done_ok  = active && gnt_valid && s_ready;
        // A slave answering in the limit cycle wins over the timeout.
        done_to  = active && gnt_valid && !s_ready && (wait_cnt == TIMEOUT_LIM);
        done_any = done_ok || done_to;
    end

    always_comb begin
        req_any = m0_valid || m1_valid;
        if (m0_valid && m1_valid) begin
            // Tie: the master not served last goes first.
            next_grant = ~last_grant;
        end else begin
            next_grant = m1_valid;
        end
    end

    // Outputs are decoded from the registered state and grant, so the
    // asynchronous reset of those registers clears every output at once.
    always_comb begin
        s_valid  = 1'b0;
        s_addr   = 32'h0;
        s_wdata  = 32'h0;
        s_wstrb  = 4'h0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = 32'h0;
        m1_rdata = 32'h0;
        err      = 1'b0;

        if (active) begin
            // The request is withdrawn in the timeout cycle and whenever the
            // granted master has dropped valid.
            s_valid = gnt_valid && !done_to;
            s_addr  = gnt_addr;
            s_wdata = gnt_wdata;
            s_wstrb = gnt_wstrb;
            err     = done_to;

            if (grant) begin
                m1_ready = done_any;
                m1_rdata = done_to ? ERR_RDATA : s_rdata;
            end else begin
                m0_ready = done_any;
                m0_rdata = done_to ? ERR_RDATA : s_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        grant    <= next_grant;
                        wait_cnt <= 16'h0;
                        state    <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (aborted) begin
                        // Protocol violation: drop the transaction without
                        // touching the round-robin history.
                        state <= IDLE;
                    end else if (done_any) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'h1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_subsys_mem_arb.sv
// Testbench for cpu_subsys_mem_arb.
// Directed stimulus drives the two masters and a small memory-backed slave;
// every expected completion is queued when issued and a negedge monitor
// compares it against whichever master ready pulses.

module tb_cpu_subsys_mem_arb;

    localparam int          TO      = 4;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_valid, s_ready, err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;

    logic [31:0] mem [0:63];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          m;
        logic [31:0] rd;
        bit          e;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    always #5 clk = ~clk;

    cpu_subsys_mem_arb #(
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (ERR_VAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_valid (m0_valid),
        .m0_ready (m0_ready),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_rdata (m0_rdata),
        .m1_valid (m1_valid),
        .m1_ready (m1_ready),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_rdata (m1_rdata),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_rdata  (s_rdata),
        .err      (err)
    );

    // Zero-wait (when s_ready is high) word-addressed slave.
    assign s_rdata = mem[s_addr[7:2]];

    always @(posedge clk) begin
        if (s_valid && s_ready) begin
            for (int b = 0; b < 4; b++) begin
                if (s_wstrb[b]) mem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input bit m, input logic [31:0] rd, input bit e);
        exp_t x;
        x.m  = m;
        x.rd = rd;
        x.e  = e;
        exp_q.push_back(x);
    endtask

    // Issue one transaction on master m and hold it until its ready pulse.
    task automatic do_txn(input bit m, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
        bit got;
        got = 1'b0;
        if (m) begin
            m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; m1_valid = 1'b1;
        end else begin
            m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; m0_valid = 1'b1;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m ? m1_ready : m0_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout master=%0d addr=%h actual=no_ready required=ready", m, addr);
        end
        @(posedge clk);
        #1;
        if (m) m1_valid = 1'b0;
        else   m0_valid = 1'b0;
    endtask

    // Completion monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_ready || m1_ready) begin
                check("dual_ready", 32'(m0_ready & m1_ready), 32'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready m0_ready=%b m1_ready=%b required=none", m0_ready, m1_ready);
                end else begin
                    cur = exp_q.pop_front();
                    check("cpl_master", 32'(m1_ready), 32'(cur.m));
                    check("cpl_rdata", m1_ready ? m1_rdata : m0_rdata, cur.rd);
                    check("cpl_err", 32'(err), 32'(cur.e));
                    check("cpl_other_rdata", m1_ready ? m0_rdata : m1_rdata, 32'h0);
                    if (cur.e) check("to_svalid", 32'(s_valid), 32'h0);
                end
            end else if (err) begin
                checks++;
                failures++;
                $display("FAIL err_without_ready actual=1 required=0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready  = 1'b1;
        rst      = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_s_valid",  32'(s_valid),  32'h0);
        check("rst_s_addr",   s_addr,        32'h0);
        check("rst_m0_ready", 32'(m0_ready), 32'h0);
        check("rst_m1_ready", 32'(m1_ready), 32'h0);
        check("rst_m0_rdata", m0_rdata,      32'h0);
        check("rst_err",      32'(err),      32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Round-robin from reset: m0, m1, m0, m1.
        push(0, 32'hA000_0008, 0);
        push(1, 32'hA000_000C, 0);
        push(0, 32'hA000_0009, 0);
        push(1, 32'hA000_000D, 0);
        fork
            begin
                do_txn(0, 32'h20, 32'h0, 4'h0);
                do_txn(0, 32'h24, 32'h0, 4'h0);
            end
            begin
                do_txn(1, 32'h30, 32'h0, 4'h0);
                do_txn(1, 32'h34, 32'h0, 4'h0);
            end
        join
        @(posedge clk);
        #1;

        // Write then read back; slave returns the pre-write word on the write.
        push(0, 32'hA000_0004, 0);
        fork
            do_txn(0, 32'h10, 32'h1234_5678, 4'hF);
            begin
                @(negedge clk);
                check("w_idle_svalid", 32'(s_valid), 32'h0);
                @(negedge clk);
                check("w_svalid_c2", 32'(s_valid), 32'h1);
                check("w_saddr",  s_addr,  32'h10);
                check("w_swdata", s_wdata, 32'h1234_5678);
                check("w_swstrb", 32'(s_wstrb), 32'hF);
                check("w_ready_c2", 32'(m0_ready), 32'h1);
            end
        join
        push(0, 32'h1234_5678, 0);
        do_txn(0, 32'h10, 32'h0, 4'h0);

        // Stalled slave: m0 times out, m1 arriving later waits then times out.
        s_ready = 1'b0;
        push(0, ERR_VAL, 1);
        push(1, ERR_VAL, 1);
        fork
            do_txn(0, 32'h40, 32'h0, 4'h0);
            begin
                @(posedge clk);
                #1;
                do_txn(1, 32'h44, 32'h0, 4'h0);
            end
            begin
                repeat (5) @(negedge clk);
                check("to_wait_ready",  32'(m0_ready), 32'h0);
                check("to_wait_svalid", 32'(s_valid),  32'h1);
                @(negedge clk);
                check("to_fire_err",   32'(err), 32'h1);
                check("to_fire_rdata", m0_rdata, ERR_VAL);
            end
        join

        // Slave answers in exactly the limit cycle: normal completion.
        push(0, 32'hA000_0011, 0);
        fork
            do_txn(0, 32'h44, 32'h0, 4'h0);
            begin
                repeat (5) @(posedge clk);
                #1;
                s_ready = 1'b1;
            end
        join

        // Asynchronous reset mid-transaction.
        s_ready  = 1'b0;
        m0_addr  = 32'h48;
        m0_wstrb = 4'h0;
        m0_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rst_pre_svalid", 32'(s_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("arst_s_valid",  32'(s_valid),  32'h0);
        check("arst_s_addr",   s_addr,        32'h0);
        check("arst_m0_ready", 32'(m0_ready), 32'h0);
        check("arst_m0_rdata", m0_rdata,      32'h0);
        check("arst_err",      32'(err),      32'h0);
        m0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        s_ready = 1'b1;
        push(1, 32'hA000_0018, 0);
        do_txn(1, 32'h60, 32'h0, 4'h0);

        // m0 completes (last-grant = 0), then m1 is granted and aborts.
        push(0, 32'hA000_0005, 0);
        do_txn(0, 32'h14, 32'h0, 4'h0);
        s_ready  = 1'b0;
        m1_addr  = 32'h64;
        m1_wstrb = 4'h0;
        m1_valid = 1'b1;
        @(posedge clk);
        #1;
        check("abort_pre_svalid", 32'(s_valid), 32'h1);
        m1_valid = 1'b0;
        #1;
        check("abort_svalid", 32'(s_valid), 32'h0);
        @(negedge clk);
        check("abort_m1_ready", 32'(m1_ready), 32'h0);
        @(posedge clk);
        #1;
        s_ready = 1'b1;
        // Last-grant still 0, so m1 wins this tie.
        push(1, 32'hA000_001A, 0);
        push(0, 32'hA000_001B, 0);
        fork
            do_txn(0, 32'h6C, 32'h0, 4'h0);
            do_txn(1, 32'h68, 32'h0, 4'h0);
        join

        @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
